// File: rtl/alu_pkg.sv
// Shared definitions for the EX/MEM pipeline register.
//   - ALU op codes as produced by the EX stage
//   - ex_bundle_t: the payload carried from EX to MEM
//   - ex_state_e: trap state of the stage
// Bundle widths are fixed here; the stage parameters default to the same values.
package alu_pkg;

  localparam int EX_WIDTH  = 32;
  localparam int EX_REG_AW = 5;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b011,
    ALU_NOR = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ex_ctrl_t;

  typedef struct packed {
    logic [EX_WIDTH-1:0]  res;
    logic [EX_WIDTH-1:0]  store_data;
    logic [EX_WIDTH-1:0]  pc;
    logic [EX_REG_AW-1:0] rd;
    ex_ctrl_t             ctrl;
    logic                 zero;
  } ex_bundle_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } ex_state_e;

  // Value held by an empty/reset slot: everything zero, so the zero flag is set.
  localparam ex_bundle_t EX_BUNDLE_RESET = '{
    res:        '0,
    store_data: '0,
    pc:         '0,
    rd:         '0,
    ctrl:       '0,
    zero:       1'b1
  };

  // Only signed ADD and SUB can raise an overflow trap.
  function automatic logic is_trap_op(input logic [2:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// Signal bundle between the EX stage, the EX/MEM register, MEM and the
// exception unit.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The receiver may drop ready at any time; the sender holds its
// payload stable while valid=1 and ready=0 if it wants it delivered.
// in_ready is registered inside the stage; out_valid comes straight from
// the stage's main buffer slot.
//
// Modports:
//   slave  - the ex_mem_stage itself
//   master - the environment (EX, MEM, exception unit, or a bench)
interface ex_mem_stage_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
);
  import alu_pkg::*;

  // EX side
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  alu_res;
  logic              alu_v;
  logic [2:0]        alu_op;
  logic              trap_en;
  logic [REG_AW-1:0] rd;
  logic              reg_write;
  logic              mem_read;
  logic              mem_write;
  logic [WIDTH-1:0]  store_data;
  logic [WIDTH-1:0]  pc;
  logic              flush;

  // MEM side
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_res;
  logic [WIDTH-1:0]  out_store_data;
  logic [WIDTH-1:0]  out_pc;
  logic [REG_AW-1:0] out_rd;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_zero;

  // Exception unit
  logic              exc_ack;
  logic              exc_valid;
  logic [WIDTH-1:0]  epc;

  // Debug view of the trap FSM
  ex_state_e         dbg_state;

  modport slave (
    input  in_valid, alu_res, alu_v, alu_op, trap_en, rd,
           reg_write, mem_read, mem_write, store_data, pc, flush,
           out_ready, exc_ack,
    output in_ready, out_valid, out_res, out_store_data, out_pc, out_rd,
           out_reg_write, out_mem_read, out_mem_write, out_zero,
           exc_valid, epc, dbg_state
  );

  modport master (
    output in_valid, alu_res, alu_v, alu_op, trap_en, rd,
           reg_write, mem_read, mem_write, store_data, pc, flush,
           out_ready, exc_ack,
    input  in_ready, out_valid, out_res, out_store_data, out_pc, out_rd,
           out_reg_write, out_mem_read, out_mem_write, out_zero,
           exc_valid, epc, dbg_state
  );

endinterface

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer over ex_bundle_t (main + skid slot).
// The output always drives from main. The caller only raises in_valid when
// the skid slot is empty (it gates its own registered ready with
// skid_full_next), so a push always fits.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous clear of both slots
//   in_valid        push in_data this edge (already qualified by caller)
//   in_data         bundle to push
//   out_valid       main slot holds data
//   out_ready       consumer takes main this edge
//   out_data        main slot payload
//   skid_full_next  skid slot occupancy after this edge
module skid_buf2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       in_valid,
  input  ex_bundle_t in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output ex_bundle_t out_data,
  output logic       skid_full_next
);

  logic       main_valid_q, main_valid_d;
  logic       skid_valid_q, skid_valid_d;
  ex_bundle_t main_data_q, main_data_d;
  ex_bundle_t skid_data_q, skid_data_d;
  logic       out_xfer;

  assign out_xfer = main_valid_q & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;

    if (flush) begin
      // Payload registers keep their last value; only occupancy is cleared.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (out_xfer) begin
        main_valid_d = skid_valid_q;
        if (skid_valid_q) begin
          main_data_d = skid_data_q;
        end
        skid_valid_d = 1'b0;
      end
      if (in_valid) begin
        // After a pop with an empty skid, main is free again, so the new
        // bundle lands in main and throughput stays at one per cycle.
        if (!main_valid_d) begin
          main_valid_d = 1'b1;
          main_data_d  = in_data;
        end else begin
          skid_valid_d = 1'b1;
          skid_data_d  = in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= EX_BUNDLE_RESET;
      skid_data_q  <= EX_BUNDLE_RESET;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid      = main_valid_q;
  assign out_data       = main_data_q;
  assign skid_full_next = skid_valid_d;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register.
// Captures the ALU result and forwarded control bits into a 2-entry skid
// buffer, computes the zero flag at capture, and detects signed overflow on
// ADD/SUB. An overflowing instruction is passed on as a bubble (no register
// or memory side effects), its pc is latched into epc and the stage stops
// accepting input until the exception unit acknowledges.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          ex_mem_stage_if slave: EX inputs, MEM outputs, flush,
//                exc_ack/exc_valid/epc and the dbg_state view of the FSM
module ex_mem_stage
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  ex_mem_stage_if.slave  bus
);

  ex_state_e         state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [WIDTH-1:0]  epc_q, epc_d;
  logic [WIDTH-1:0]  res_in;
  logic [REG_AW-1:0] rd_in;
  logic              in_xfer;
  logic              trap_cond;
  logic              trap_fire;
  logic              skid_full_next;
  logic              buf_out_valid;
  ex_bundle_t        in_bundle;
  ex_bundle_t        out_bundle;

  assign res_in = bus.alu_res;
  assign rd_in  = bus.rd;

  // flush discards any same-edge input transfer.
  assign in_xfer   = bus.in_valid & in_ready_q & ~bus.flush;
  assign trap_cond = bus.trap_en & bus.alu_v & is_trap_op(bus.alu_op);
  assign trap_fire = in_xfer & trap_cond;

  always_comb begin
    in_bundle                = EX_BUNDLE_RESET;
    in_bundle.res            = res_in;
    in_bundle.store_data     = bus.store_data;
    in_bundle.pc             = bus.pc;
    in_bundle.rd             = rd_in;
    // A trapping instruction still occupies a slot so older entries drain in
    // order, but it must not write the register file or memory.
    in_bundle.ctrl.reg_write = bus.reg_write & ~trap_cond;
    in_bundle.ctrl.mem_read  = bus.mem_read & ~trap_cond;
    in_bundle.ctrl.mem_write = bus.mem_write & ~trap_cond;
    in_bundle.zero           = (res_in == '0);
  end

  skid_buf2 u_buf (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (bus.flush),
    .in_valid       (in_xfer),
    .in_data        (in_bundle),
    .out_valid      (buf_out_valid),
    .out_ready      (bus.out_ready),
    .out_data       (out_bundle),
    .skid_full_next (skid_full_next)
  );

  // Trap FSM: next state, epc and registered in_ready.
  always_comb begin
    state_d = state_q;
    epc_d   = epc_q;

    if (bus.flush) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (trap_fire) begin
            state_d = TRAP;
            epc_d   = bus.pc;
          end
        end
        TRAP: begin
          if (bus.exc_ack) begin
            state_d = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end

    // Requiring RUN both now and next keeps in_ready low on the edge that
    // leaves TRAP, so input reopens one cycle after exc_valid drops.
    in_ready_d = bus.flush |
                 (~skid_full_next & (state_q == RUN) & (state_d == RUN));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      in_ready_q <= 1'b1;
      epc_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      epc_q      <= epc_d;
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = buf_out_valid;
  assign bus.out_res        = out_bundle.res;
  assign bus.out_store_data = out_bundle.store_data;
  assign bus.out_pc         = out_bundle.pc;
  assign bus.out_rd         = out_bundle.rd;
  assign bus.out_reg_write  = out_bundle.ctrl.reg_write;
  assign bus.out_mem_read   = out_bundle.ctrl.mem_read;
  assign bus.out_mem_write  = out_bundle.ctrl.mem_write;
  assign bus.out_zero       = out_bundle.zero;
  assign bus.exc_valid      = (state_q == TRAP);
  assign bus.epc            = epc_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios followed by random traffic.
// A reference model (occupancy count + expected-bundle queue + trap flag)
// pushes expected outputs as inputs are accepted; a monitor compares on
// every falling edge and pops when MEM takes a bundle.
module tb_ex_mem_stage;
  import alu_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int BW = 3*W + AW + 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  ex_mem_stage_if #(.WIDTH(W), .REG_AW(AW)) bus ();

  ex_mem_stage #(.WIDTH(W), .REG_AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  logic [BW-1:0] exp_q[$];
  int            held = 0;          // bundles the stage should be holding
  logic          model_ready = 1'b1;
  logic          trapped = 1'b0;
  logic [W-1:0]  exp_epc = '0;

  function automatic logic [BW-1:0] pack(input logic [W-1:0] res, input logic [W-1:0] sd,
                                         input logic [W-1:0] pc, input logic [AW-1:0] rd,
                                         input logic rw, input logic mr, input logic mw,
                                         input logic z);
    return {res, sd, pc, rd, rw, mr, mw, z};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Rules: at most two bundles held; a bundle is accepted when in_valid and
  // the (registered) ready prediction are high; signed ADD/SUB overflow
  // becomes a side-effect-free bubble and parks the stage until exc_ack;
  // input reopens one cycle after leaving the trap; flush empties everything.
  task automatic model_step();
    bit acc, was_trapped, trap;
    acc = bus.in_valid && model_ready && !bus.flush;
    if (bus.flush) begin
      held = 0;
      exp_q.delete();
      trapped = 1'b0;
      model_ready = 1'b1;
      return;
    end
    was_trapped = trapped;
    if (held > 0 && bus.out_ready) held--;
    if (trapped && bus.exc_ack) trapped = 1'b0;
    if (acc) begin
      trap = bus.trap_en && bus.alu_v &&
             (bus.alu_op == ALU_ADD || bus.alu_op == ALU_SUB);
      exp_q.push_back(pack(bus.alu_res, bus.store_data, bus.pc, bus.rd,
                           bus.reg_write && !trap, bus.mem_read && !trap,
                           bus.mem_write && !trap, bus.alu_res == 0));
      held++;
      if (trap) begin
        trapped = 1'b1;
        exp_epc = bus.pc;
      end
    end
    model_ready = (held < 2) && !was_trapped && !trapped;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        held = 0;
        exp_q.delete();
        trapped = 1'b0;
        model_ready = 1'b1;
        exp_epc = '0;
      end else begin
        model_step();
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("out_valid", bus.out_valid, held > 0);
        check("in_ready", bus.in_ready, model_ready);
        check("exc_valid", bus.exc_valid, trapped);
        check("epc", bus.epc, exp_epc);
        if (bus.out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_out: got bundle %h expected none at %0t",
                     pack(bus.out_res, bus.out_store_data, bus.out_pc, bus.out_rd,
                          bus.out_reg_write, bus.out_mem_read, bus.out_mem_write,
                          bus.out_zero), $time);
          end else begin
            check("bundle", pack(bus.out_res, bus.out_store_data, bus.out_pc, bus.out_rd,
                                 bus.out_reg_write, bus.out_mem_read, bus.out_mem_write,
                                 bus.out_zero), exp_q[0]);
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.alu_res = '0; bus.alu_v = 1'b0; bus.alu_op = 3'b000;
    bus.trap_en = 1'b0; bus.rd = '0; bus.reg_write = 1'b0; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0; bus.store_data = '0; bus.pc = '0; bus.flush = 1'b0;
    bus.exc_ack = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] res, input logic v, input logic [2:0] op,
                      input logic ten, input logic [AW-1:0] rd, input logic rw,
                      input logic mr, input logic mw, input logic [W-1:0] sd,
                      input logic [W-1:0] pc);
    bus.in_valid = 1'b1; bus.alu_res = res; bus.alu_v = v; bus.alu_op = op;
    bus.trap_en = ten; bus.rd = rd; bus.reg_write = rw; bus.mem_read = mr;
    bus.mem_write = mw; bus.store_data = sd; bus.pc = pc;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_in_ready"}, bus.in_ready, 1'b1);
    check({tag, "_exc_valid"}, bus.exc_valid, 1'b0);
    check({tag, "_data"}, {bus.out_res, bus.out_store_data, bus.out_pc, bus.out_rd}, '0);
    check({tag, "_ctrl"}, {bus.out_reg_write, bus.out_mem_read, bus.out_mem_write}, 3'b000);
    check({tag, "_zero"}, bus.out_zero, 1'b1);
    check({tag, "_epc"}, bus.epc, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_inputs();
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    step(2);
    @(negedge clk) rst_n = 1'b1;
    step(1);

    // Stream of ADD results, MEM always ready.
    bus.out_ready = 1'b1;
    send(32'h0000_0005, 1'b0, ALU_ADD, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 32'h11, 32'h0040_0000); step(1);
    send(32'h0000_0000, 1'b0, ALU_ADD, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 32'h22, 32'h0040_0004); step(1);
    send(32'hFFFF_FFFF, 1'b0, ALU_ADD, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 32'h33, 32'h0040_0008); step(1);
    idle_inputs(); step(2);

    // Back-pressure: MEM stalls for 3 cycles with EX streaming.
    bus.out_ready = 1'b0;
    send(32'h0000_00A1, 1'b0, ALU_OR,  1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h44, 32'h0040_0100); step(1);
    send(32'h0000_00A2, 1'b0, ALU_AND, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0, 32'h55, 32'h0040_0104); step(1);
    send(32'h0000_00A3, 1'b0, ALU_XOR, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1, 32'h66, 32'h0040_0108); step(1);
    idle_inputs(); bus.out_ready = 1'b1; step(4);

    // Overflow trap on a signed ADD, then acknowledge.
    send(32'h8000_0000, 1'b1, ALU_ADD, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0040_0010); step(1);
    idle_inputs(); step(3);
    bus.exc_ack = 1'b1; step(1);
    bus.exc_ack = 1'b0; step(3);

    // Overflow without a trap: unsigned ADDU, and SLT.
    send(32'h8000_0001, 1'b1, ALU_ADD, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 32'h88, 32'h0040_0020); step(1);
    send(32'h0000_0001, 1'b1, ALU_SLT, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'h99, 32'h0040_0024); step(1);
    idle_inputs(); step(2);
    bus.exc_ack = 1'b1; step(1);   // ack while running has no effect
    bus.exc_ack = 1'b0; step(1);

    // Fill both entries, then flush while EX offers another bundle.
    bus.out_ready = 1'b0;
    send(32'h0000_0B01, 1'b0, ALU_SUB, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 32'hB1, 32'h0040_0200); step(1);
    send(32'h0000_0B02, 1'b0, ALU_SUB, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 32'hB2, 32'h0040_0204); step(1);
    send(32'h0000_0B03, 1'b0, ALU_SUB, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 32'hB3, 32'h0040_0208);
    bus.flush = 1'b1; step(1);
    idle_inputs(); step(1);
    bus.out_ready = 1'b1; step(2);

    // Two held entries plus an active trap, then async reset mid-cycle.
    bus.out_ready = 1'b0;
    send(32'h0000_0C01, 1'b0, ALU_ADD, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0, 32'hC1, 32'h0040_0300); step(1);
    send(32'h7FFF_FFFF, 1'b1, ALU_SUB, 1'b1, 5'd14, 1'b1, 1'b0, 1'b1, 32'hC2, 32'h0040_0304); step(1);
    idle_inputs(); step(1);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk) rst_n = 1'b1;
    step(1);
    bus.out_ready = 1'b1;
    send(32'h0000_0000, 1'b0, ALU_NOR, 1'b0, 5'd15, 1'b1, 1'b1, 1'b0, 32'hD1, 32'h0040_0400); step(1);
    idle_inputs(); step(2);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.alu_res    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
      bus.alu_v      = ($urandom_range(0, 5) == 0);
      bus.alu_op     = 3'($urandom_range(0, 7));
      bus.trap_en    = 1'($urandom_range(0, 1));
      bus.rd         = 5'($urandom_range(0, 31));
      bus.reg_write  = 1'($urandom_range(0, 1));
      bus.mem_read   = 1'($urandom_range(0, 1));
      bus.mem_write  = 1'($urandom_range(0, 1));
      bus.store_data = $urandom();
      bus.pc         = $urandom();
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.exc_ack    = ($urandom_range(0, 3) == 0);
      bus.flush      = ($urandom_range(0, 49) == 0);
      step(1);
    end

    // Drain.
    idle_inputs();
    bus.out_ready = 1'b1;
    bus.exc_ack = 1'b1;
    step(6);
    bus.exc_ack = 1'b0;
    step(1);
    check("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
